// File: rtl/uart_core.sv
// uart_core: 8N1 UART with an independent receiver and transmitter.
// Define UART_CORE_FRAME_ERR_EN to drop frames whose stop bit reads low.

module uart_core #(
    parameter int CLK_FREQ  = 12000000,
    parameter int UART_FREQ = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    output logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_frame_err,
    input  logic       tx_write,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_finished
);

    localparam int DIV  = CLK_FREQ / UART_FREQ;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ---------------- receiver ----------------

    logic          rx_meta_q, rx_meta_d;
    logic          rx_sync_q, rx_sync_d;
    logic [1:0]    rx_warm_q, rx_warm_d;
    logic          rx_armed_q, rx_armed_d;
    state_t        rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_ready_q, rx_ready_d;
    logic          rx_err_q, rx_err_d;
    logic          rx_tick;
    logic          rx_stop_ok;

    assign rx_tick = (rx_cnt_q == '0);

`ifdef UART_CORE_FRAME_ERR_EN
    assign rx_stop_ok = rx_sync_q;
`else
    assign rx_stop_ok = 1'b1;
`endif

    // RX state register plus synchronizer and datapath flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_warm_q  <= 2'b00;
            rx_armed_q <= 1'b0;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_ready_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_warm_q  <= rx_warm_d;
            rx_armed_q <= rx_armed_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
            rx_err_q   <= rx_err_d;
        end
    end

    // RX next state: start on a low line, abort on a glitch, walk bits
    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            S_IDLE:  if (rx_armed_q && !rx_sync_q) rx_state_d = S_START;
            S_START: if (rx_tick) rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_bit_q == 3'd7) rx_state_d = S_STOP;
            S_STOP:  if (rx_tick) rx_state_d = S_IDLE;
            default: rx_state_d = S_IDLE;
        endcase
    end

    // RX datapath: sampling counter, shifter and delivery pulses
    always_comb begin
        rx_meta_d  = rx;
        rx_sync_d  = rx_meta_q;
        rx_warm_d  = {rx_warm_q[0], 1'b1};
        rx_armed_d = rx_armed_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_ready_d = 1'b0;
        rx_err_d   = 1'b0;
        // the line must be seen high (past the reset value) before a start
        if (rx_state_q == S_IDLE && rx_sync_q && rx_warm_q[1])
            rx_armed_d = 1'b1;
        unique case (rx_state_q)
            S_IDLE: begin
                if (rx_armed_q && !rx_sync_q) begin
                    rx_armed_d = 1'b0;
                    rx_cnt_d   = HALF_M1;
                end
            end
            S_START: begin
                if (rx_tick) begin
                    rx_cnt_d = rx_sync_q ? '0 : DIV_M1;
                    rx_bit_d = '0;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (rx_tick) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    rx_cnt_d   = DIV_M1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (rx_tick) begin
                    rx_cnt_d = '0;
                    if (rx_stop_ok) begin
                        rx_data_d  = rx_shift_q;
                        rx_ready_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            default: rx_cnt_d = '0;
        endcase
    end

    assign rx_ready     = rx_ready_q;
    assign rx_data      = rx_data_q;
    assign rx_frame_err = rx_err_q;

    // ---------------- transmitter ----------------

    state_t        tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;
    logic          tx_busy_q, tx_busy_d;
    logic          tx_fin_q, tx_fin_d;
    logic          tx_tick;

    assign tx_tick = (tx_cnt_q == '0);

    // TX state register and registered line/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_fin_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_fin_q   <= tx_fin_d;
        end
    end

    // TX next state: requests are only honoured from idle
    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            S_IDLE:  if (tx_write) tx_state_d = S_START;
            S_START: if (tx_tick) tx_state_d = S_DATA;
            S_DATA:  if (tx_tick && tx_bit_q == 3'd7) tx_state_d = S_STOP;
            S_STOP:  if (tx_tick) tx_state_d = S_IDLE;
            default: tx_state_d = S_IDLE;
        endcase
    end

    // TX datapath and outputs, computed from next state so they register
    always_comb begin
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        unique case (tx_state_q)
            S_IDLE: begin
                if (tx_write) begin
                    tx_shift_d = tx_data;
                    tx_cnt_d   = DIV_M1;
                    tx_bit_d   = '0;
                end
            end
            S_START: begin
                tx_cnt_d = tx_tick ? DIV_M1 : tx_cnt_q - 1'b1;
            end
            S_DATA: begin
                if (tx_tick) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_cnt_d   = DIV_M1;
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                tx_cnt_d = tx_tick ? '0 : tx_cnt_q - 1'b1;
            end
            default: tx_cnt_d = '0;
        endcase

        tx_d      = 1'b1;
        tx_busy_d = 1'b0;
        tx_fin_d  = 1'b0;
        unique case (tx_state_d)
            S_START: begin
                tx_d      = 1'b0;
                tx_busy_d = 1'b1;
            end
            S_DATA: begin
                tx_d      = tx_shift_d[0];
                tx_busy_d = 1'b1;
            end
            S_STOP: begin
                tx_busy_d = (tx_cnt_d != '0);
                tx_fin_d  = (tx_cnt_d == '0);
            end
            default: tx_d = 1'b1;
        endcase
    end

    assign tx          = tx_q;
    assign tx_busy     = tx_busy_q;
    assign tx_finished = tx_fin_q;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed bench with scoreboards for both UART directions.
// Expected RX events and TX bytes are queued when stimulus is driven.

module tb_uart_core;

    localparam int DIV = 12000000 / 115200;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } rx_ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_drv;
    logic       loopback;
    logic       rx_line;
    logic       tx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       tx_write;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_finished;

    int checks = 0;
    int passed = 0;
    int failed = 0;
    int cyc = 0;
    int rdy_cnt = 0;
    int rdy_cyc = 0;
    int fall_cyc = 0;

    rx_ev_t     rx_exp[$];
    logic [7:0] tx_exp[$];

    assign rx_line = loopback ? tx : rx_drv;

    uart_core #(
        .CLK_FREQ (12000000),
        .UART_FREQ(115200)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx_line),
        .tx          (tx),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_frame_err(rx_frame_err),
        .tx_write    (tx_write),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_finished (tx_finished)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RX scoreboard: every pulse must match the next queued event
    always @(negedge clk) begin
        rx_ev_t e;
        if (rx_ready || rx_frame_err) begin
            if (rx_exp.size() == 0) begin
                chk("rx_unexpected_pulse", {rx_ready, rx_frame_err}, 0);
            end else begin
                e = rx_exp.pop_front();
                chk("rx_event_kind", {rx_ready, rx_frame_err}, e.kind);
                chk("rx_event_data", rx_data, e.data);
            end
            if (rx_ready) begin
                rdy_cnt++;
                rdy_cyc = cyc;
            end
        end
    end

    // TX scoreboard: per-clock line and busy check against queued byte
    logic       tm_act = 1'b0;
    int         tm_n = 0;
    int         tm_errs = 0;
    logic [9:0] tm_pat = '1;

    always @(negedge clk) begin
        if (reset) begin
            tm_act = 1'b0;
        end else if (!tm_act) begin
            if (tx_finished) chk("tx_fin_outside_frame", tx_finished, 0);
            if (tx === 1'b0) begin
                tm_act  = 1'b1;
                tm_n    = 0;
                tm_errs = 0;
                chk("tx_frame_expected", tx_exp.size() != 0, 1);
                if (tx_exp.size() != 0) tm_pat = {1'b1, tx_exp.pop_front(), 1'b0};
            end
        end
        if (tm_act && !reset) begin
            if (tm_n < 10 * DIV) begin
                if (tx !== tm_pat[tm_n / DIV]) tm_errs++;
                if (tx_busy !== (tm_n != 10 * DIV - 1)) tm_errs++;
            end
            if (tx_finished) begin
                chk("tx_fin_clock", tm_n + 1, 10 * DIV);
                chk("tx_frame_bits", tm_errs, 0);
                tm_act = 1'b0;
            end else if (tm_n >= 10 * DIV + 10) begin
                chk("tx_fin_timeout", tm_n, 10 * DIV - 1);
                tm_act = 1'b0;
            end
            tm_n++;
        end
    end

    task automatic send_tx(input logic [7:0] d, input logic expect_it);
        @(posedge clk);
        #1 tx_write = 1'b1;
        tx_data = d;
        if (expect_it) tx_exp.push_back(d);
        @(posedge clk);
        #1 tx_write = 1'b0;
    endtask

    task automatic poke_tx(input logic [7:0] d);
        @(posedge clk);
        #1 tx_write = 1'b1;
        tx_data = d;
        @(posedge clk);
        #1 tx_write = 1'b0;
    endtask

    task automatic wait_fin(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 1500 && !seen; i++) begin
            @(negedge clk);
            if (tx_finished) seen = 1'b1;
        end
        chk(tag, seen, 1);
    endtask

    task automatic wait_rdy(input int target, input string tag);
        for (int i = 0; i < 2500 && rdy_cnt < target; i++) @(negedge clk);
        chk(tag, rdy_cnt, target);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1 rx_drv = f[k];
            if (k == 0) fall_cyc = cyc;
            repeat (DIV - 1) @(posedge clk);
        end
        @(posedge clk);
        #1 rx_drv = 1'b1;
    endtask

    initial begin
        int base;
        int lat;
        rx_drv   = 1'b1;
        loopback = 1'b0;
        tx_write = 1'b0;
        tx_data  = 8'h00;
        reset    = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_tx_busy", tx_busy, 0);
        chk("reset_tx_finished", tx_finished, 0);
        chk("reset_rx_ready", rx_ready, 0);
        chk("reset_rx_frame_err", rx_frame_err, 0);
        chk("reset_rx_data", rx_data, 8'h00);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);

        // A5 frame with ignored writes mid-frame, then back-to-back 3C
        send_tx(8'hA5, 1'b1);
        repeat (3) @(posedge clk);
        poke_tx(8'hFF);
        repeat (492) @(posedge clk);
        poke_tx(8'h00);
        wait_fin("tx_a5_finished");
        send_tx(8'h3C, 1'b1);
        @(negedge clk);
        chk("b2b_tx_low", tx, 0);
        chk("b2b_tx_busy", tx_busy, 1);
        wait_fin("tx_3c_finished");
        repeat (20) @(posedge clk);

        // RX 3C frame and latency from the start edge
        base = rdy_cnt;
        rx_exp.push_back({2'b10, 8'h3C});
        rx_frame(8'h3C, 1'b1);
        repeat (20) @(posedge clk);
        lat = rdy_cyc - fall_cyc;
        chk("rx_3c_count", rdy_cnt - base, 1);
        chk("rx_latency_window", (lat >= 980 && lat <= 1000), 1);
        chk("rx_data_held", rx_data, 8'h3C);

        // 30-clock glitch must not produce a byte; next frame still good
        base = rdy_cnt;
        @(posedge clk);
        #1 rx_drv = 1'b0;
        repeat (30) @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (200) @(posedge clk);
        chk("glitch_no_ready", rdy_cnt - base, 0);
        rx_exp.push_back({2'b10, 8'h55});
        rx_frame(8'h55, 1'b1);
        repeat (20) @(posedge clk);
        chk("after_glitch_count", rdy_cnt - base, 1);
        chk("after_glitch_data", rx_data, 8'h55);

        // 81 with a low stop bit
`ifdef UART_CORE_FRAME_ERR_EN
        rx_exp.push_back({2'b01, 8'h55});
        rx_frame(8'h81, 1'b0);
        repeat (200) @(posedge clk);
        chk("bad_stop_rx_data", rx_data, 8'h55);
`else
        rx_exp.push_back({2'b10, 8'h81});
        rx_frame(8'h81, 1'b0);
        repeat (200) @(posedge clk);
        chk("bad_stop_rx_data", rx_data, 8'h81);
`endif

        // reset while both directions are in their data bits
        @(posedge clk);
        #1 rx_drv = 1'b0;
        send_tx(8'hC3, 1'b1);
        repeat (400) @(posedge clk);
        #1;
        chk("pre_reset_tx_low", tx, 0);
        chk("pre_reset_tx_busy", tx_busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_tx_high", tx, 1);
        chk("async_reset_tx_busy", tx_busy, 0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        base = rdy_cnt;
        repeat (300) @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (300) @(posedge clk);
        chk("no_start_on_low_line", rdy_cnt - base, 0);
        chk("tx_idle_after_reset", tx, 1);

        // 00 round trip through a tx->rx loopback
        loopback = 1'b1;
        repeat (20) @(posedge clk);
        rx_exp.push_back({2'b10, 8'h00});
        send_tx(8'h00, 1'b1);
        wait_rdy(base + 1, "roundtrip_ready");
        chk("roundtrip_data", rx_data, 8'h00);
        wait_fin("roundtrip_tx_finished");
        repeat (50) @(posedge clk);

        chk("rx_queue_drained", rx_exp.size(), 0);
        chk("tx_queue_drained", tx_exp.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
